// File: rtl/if_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package if_fetch_pkg;

    localparam int unsigned DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    // FETCH issues requests normally; DROP waits out a request made stale by a redirect.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    // One prefetched instruction together with the address that follows it.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetch_entry_t;

    // Address of the next sequential word. Arithmetic wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + WORD_BYTES;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Prefetch FIFO: circular buffer of fetch entries with push, pop and flush.
// Flush takes priority over push and pop. A push into a full FIFO is accepted
// only when a pop happens in the same cycle, so the count stays unchanged.
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            push_s;
    logic            pop_s;

    // Qualify push/pop against flush and occupancy, then compute pointer and count updates.
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = CNT_ZERO;
        end else begin
            pop_s  = pop_i && (count_q != CNT_ZERO);
            push_s = push_i && ((count_q != CNT_FULL) || pop_s);
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while unoccupied, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head view is forced to zero while empty so downstream never sees stale data.
    always_comb begin
        valid_o = (count_q != CNT_ZERO);
        count_o = count_q;
        if (count_q != CNT_ZERO) begin
            head_o = mem_q[rd_ptr_q];
        end else begin
            head_o = '0;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs the req/ack handshake
// with instruction memory and buffers returned words in a prefetch FIFO.
// A redirect flushes the FIFO; a request already issued to memory must still
// be completed, and its data is thrown away (DROP state).
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    fetch_pc_d;
    logic [31:0]    req_addr_q;
    logic [31:0]    req_addr_d;
    logic           inflight_q;
    logic           inflight_d;

    logic           req_s;
    logic [31:0]    addr_s;
    logic           ack_s;
    logic           push_s;
    logic           pop_s;
    logic           flush_s;
    fetch_entry_t   push_data_s;
    fetch_entry_t   head_s;
    logic           fifo_valid_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_full_s;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_s),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_count_s)
    );

    // Handshake qualifiers. A request is only started with room in the FIFO and,
    // once started, stays up (same address) until acked. Holding reset low
    // drops the request immediately.
    always_comb begin
        fifo_full_s = (fifo_count_s == CNT_FULL);
        req_s       = rst_i && (inflight_q || ((state_q == FETCH) && !fifo_full_s));
        if (inflight_q) begin
            addr_s = req_addr_q;
        end else begin
            addr_s = fetch_pc_q;
        end
        ack_s       = req_s && imem_ack_i;
        pop_s       = fifo_valid_s && !stall_i && !redirect_i;
        push_s      = (state_q == FETCH) && ack_s && !redirect_i;
        flush_s     = redirect_i;
        push_data_s = '{pc4: next_word_addr(addr_s), instr: imem_rdata_i};
    end

    // State register: FSM state, fetch PC and in-flight request tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
        end
    end

    // Next-state logic: redirect wins over everything; an unacked request at
    // redirect time forces DROP so its data is discarded when it returns.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = req_s && !ack_s;
        if (req_s) begin
            req_addr_d = addr_s;
        end else begin
            req_addr_d = req_addr_q;
        end
        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    if (req_s && !ack_s) begin
                        state_d = DROP;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (ack_s) begin
                    fetch_pc_d = next_word_addr(addr_s);
                    state_d    = FETCH;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (ack_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d    = FETCH;
                fetch_pc_d = fetch_pc_q;
            end
        endcase
    end

    // Output logic: memory handshake and FIFO head presentation.
    always_comb begin
        imem_req_o  = req_s;
        imem_addr_o = addr_s;
        valid_o     = fifo_valid_s;
        if (fifo_valid_s) begin
            instr_o = head_s.instr;
            pc4_o   = head_s.pc4;
        end else begin
            instr_o = 32'h0000_0000;
            pc4_o   = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue. The memory model returns
// instr = 32'hE000_0000 | addr, so expected instructions are known constants.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;

    logic        zw;
    logic        ack_man;

    int n_assert;
    int n_fail;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .valid_o       (valid),
        .instr_o       (instr),
        .pc4_o         (pc4)
    );

    assign imem_rdata = 32'hE000_0000 | imem_addr;
    assign imem_ack   = imem_req & (zw | ack_man);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        ack_man = 1'b0;
        step();
        step();
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        zw = 1'b1;
        ack_man = 1'b0;

        // ---- reset state
        step();
        step();
        settle();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // ---- zero-wait streaming
        rst = 1'b1;
        settle();
        check("zw_c1_req", {31'd0, imem_req}, 32'd1);
        check("zw_c1_addr", imem_addr, 32'h0);
        check("zw_c1_valid", {31'd0, valid}, 32'd0);
        step();
        check("zw_c2_addr", imem_addr, 32'h4);
        check("zw_c2_valid", {31'd0, valid}, 32'd1);
        check("zw_c2_pc4", pc4, 32'h4);
        check("zw_c2_instr", instr, 32'hE000_0000);
        step();
        check("zw_c3_addr", imem_addr, 32'h8);
        check("zw_c3_pc4", pc4, 32'h8);
        check("zw_c3_instr", instr, 32'hE000_0004);
        step();
        check("zw_c4_addr", imem_addr, 32'hC);
        check("zw_c4_pc4", pc4, 32'hC);
        step();
        check("zw_c5_pc4", pc4, 32'h10);
        check("zw_c5_instr", instr, 32'hE000_000C);

        // ---- 3-cycle latency, stall held: fill to DEPTH
        do_reset();
        zw = 1'b0;
        stall = 1'b1;
        rst = 1'b1;
        settle();
        for (int r = 0; r < 4; r++) begin
            check("lat_req", {31'd0, imem_req}, 32'd1);
            check("lat_addr", imem_addr, 32'(r * 4));
            ack_man = 1'b0;
            step();
            check("lat_hold_addr", imem_addr, 32'(r * 4));
            step();
            ack_man = 1'b1;
            settle();
            step();
            ack_man = 1'b0;
            settle();
        end
        check("full_req", {31'd0, imem_req}, 32'd0);
        check("full_valid", {31'd0, valid}, 32'd1);
        check("full_pc4", pc4, 32'h4);
        check("full_instr", instr, 32'hE000_0000);
        step();
        check("full_req2", {31'd0, imem_req}, 32'd0);
        check("full_pc4_2", pc4, 32'h4);
        // release stall for one pop
        stall = 1'b0;
        settle();
        check("pop1_pc4", pc4, 32'h4);
        check("pop1_req", {31'd0, imem_req}, 32'd0);
        step();
        stall = 1'b1;
        settle();
        check("after_pop_pc4", pc4, 32'h8);
        check("after_pop_req", {31'd0, imem_req}, 32'd1);
        check("after_pop_addr", imem_addr, 32'h10);
        step();
        check("pend_addr", imem_addr, 32'h10);
        // push and pop in the same cycle
        stall = 1'b0;
        ack_man = 1'b1;
        settle();
        check("pp_pc4", pc4, 32'h8);
        step();
        ack_man = 1'b0;
        settle();
        check("pp_next_pc4", pc4, 32'hC);
        check("pp_next_addr", imem_addr, 32'h14);
        step();
        check("drain_pc4_10", pc4, 32'h10);
        check("drain_instr_10", instr, 32'hE000_000C);
        step();
        check("drain_pc4_14", pc4, 32'h14);
        check("drain_instr_14", instr, 32'hE000_0010);
        step();
        check("drain_empty_valid", {31'd0, valid}, 32'd0);
        check("drain_empty_pc4", pc4, 32'h0);
        check("drain_empty_instr", instr, 32'h0);

        // ---- redirect while request for 0x8 pending -> DROP
        do_reset();
        zw = 1'b0;
        rst = 1'b1;
        ack_man = 1'b1;
        settle();
        step();
        step();
        ack_man = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        settle();
        check("rd_c3_addr", imem_addr, 32'h8);
        check("rd_c3_valid", {31'd0, valid}, 32'd1);
        step();
        redirect = 1'b0;
        settle();
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_addr", imem_addr, 32'h8);
        check("drop_valid", {31'd0, valid}, 32'd0);
        step();
        ack_man = 1'b1;
        settle();
        check("drop_ack_addr", imem_addr, 32'h8);
        step();
        check("drop_after_valid", {31'd0, valid}, 32'd0);
        check("drop_after_addr", imem_addr, 32'h100);
        check("drop_after_req", {31'd0, imem_req}, 32'd1);
        step();
        ack_man = 1'b0;
        settle();
        check("tgt_valid", {31'd0, valid}, 32'd1);
        check("tgt_pc4", pc4, 32'h104);
        check("tgt_instr", instr, 32'hE000_0100);

        // ---- redirect coincident with ack for 0xC
        do_reset();
        zw = 1'b1;
        rst = 1'b1;
        settle();
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        settle();
        check("rda_addr", imem_addr, 32'hC);
        check("rda_valid", {31'd0, valid}, 32'd1);
        check("rda_pc4", pc4, 32'hC);
        step();
        redirect = 1'b0;
        settle();
        check("rda_empty", {31'd0, valid}, 32'd0);
        check("rda_next_addr", imem_addr, 32'h40);
        step();
        check("rda_tgt_pc4", pc4, 32'h44);
        check("rda_tgt_instr", instr, 32'hE000_0040);

        // ---- reset asserted mid-DROP
        do_reset();
        zw = 1'b0;
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        settle();
        step();
        redirect = 1'b0;
        settle();
        check("mdrop_req", {31'd0, imem_req}, 32'd1);
        check("mdrop_addr", imem_addr, 32'h0);
        rst = 1'b0;
        settle();
        check("mdrop_rst_req", {31'd0, imem_req}, 32'd0);
        step();
        check("mdrop_post_valid", {31'd0, valid}, 32'd0);
        check("mdrop_post_req", {31'd0, imem_req}, 32'd0);
        check("mdrop_post_addr", imem_addr, 32'h0);
        rst = 1'b1;
        zw = 1'b1;
        settle();
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h0);
        step();
        check("resume_pc4", pc4, 32'h4);
        check("resume_instr", instr, 32'hE000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
